reg_writeback_buffer: RTL
=========================

// Module: reg_writeback_buffer
// PURPOSE
//  Write-side companion of the register file: collects writeback results (dest reg + data)
//  from execute/memory through a valid/ready handshake, queues them in a small FIFO and
//  drains one per cycle into the register-file write port (reg_write/write_reg/write_data).
//  Two combinational bypass ports let decode see queued-but-unwritten values for read_reg1/2.
// PARAMETERS
//  WORD   64  data width; matches register-file word width
//  DEPTH  4   FIFO entries; power of two, >= 2
//  ZR     31  architectural zero register (XZR); never written, never forwarded
// PORTS
//  read_clk    in   1     clock; all state updates on posedge
//  reset       in   1     synchronous, active-low
//  flush       in   1     synchronous discard of all queued entries
//  wb_valid    in   1     writeback request valid
//  wb_ready    out  1     buffer can accept (= !full)
//  wb_reg      in   5     destination register
//  wb_data     in   WORD  destination data
//  drain_en    in   1     register-file write port available this cycle
//  reg_write   out  1     registered write strobe to register file
//  write_reg   out  5     registered write address
//  write_data  out  WORD  registered write data
//  byp_reg1    in   5     bypass lookup address 1
//  byp_hit1    out  1     pending value exists for byp_reg1
//  byp_data1   out  WORD  newest pending value for byp_reg1 (0 when no hit)
//  byp_reg2    in   5     bypass lookup address 2
//  byp_hit2    out  1     as byp_hit1 for byp_reg2
//  byp_data2   out  WORD  as byp_data1 for byp_reg2
//  count       out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (reset==0 at posedge): head=tail=count=0, all entries invalid, reg_write=0,
//   write_reg=0, write_data=0. Reset wins over flush, enqueue and drain in the same cycle.
//  Enqueue: at posedge when wb_valid && wb_ready && !flush: store {wb_reg,wb_data} at tail,
//   tail++ (wraps mod DEPTH), count++. wb_reg==ZR is accepted (handshake completes) but
//   dropped: no entry created, count unchanged.
//  wb_ready = (count != DEPTH); purely from count, no dependency on drain_en (no full bypass).
//  Drain: at posedge when drain_en && count!=0 && !flush: reg_write<=1, write_reg/write_data
//   <= head entry, head++ (wraps), count--. Otherwise reg_write<=0; write_reg/write_data hold.
//  Enqueue and drain in the same cycle: count unchanged; drain uses pre-edge head (entry
//   enqueued this edge is never drained this edge). Empty buffer: first write strobe appears
//   one cycle after the accepting edge (latency 1 to reg_write, min 2 edges to reg-file commit).
//  Flush: head=tail=count=0, reg_write<=0; wb_valid in that cycle is not accepted into the FIFO
//   (wb_ready still reflects pre-flush count; requester must not rely on acceptance under flush).
//  Ordering: strict FIFO; writes to same reg commit in arrival order.
//  Bypass (combinational): search valid FIFO entries plus the output stage (when reg_write==1);
//   priority newest FIFO entry > older FIFO entries > output stage. byp_regN==ZR -> hit=0,
//   data=0. No hit -> data=0. Bypass does not see wb_* of the current cycle.
//  No state machine beyond FIFO pointers; count is the single source for full/empty.
// TESTING
//  1 Reset: hold reset=0 2 cycles with wb_valid=1 -> count=0, reg_write=0, wb_ready=1 after release.
//  2 Single: enq X5=0xAA, drain_en=1 -> next cycle reg_write=1, write_reg=5, write_data=0xAA; then 0.
//  3 Full: drain_en=0, enq X1..X4 -> count=4, wb_ready=0; 5th wb_valid ignored; drain -> X1..X4 in order.
//  4 Bypass: queue X7=1 then X7=2, drain_en=0 -> byp_reg1=7 gives hit=1,data=2; byp_reg2=31 -> hit=0,data=0.
//  5 Simultaneous: count=2, enq+drain same edge -> count stays 2; pointers wrap after DEPTH+3 ops, order kept.
//  6 Flush/ZR: enq X31 -> count 0, no strobe; queue 3 then flush -> count=0, reg_write=0, hits=0.

Source files
------------

// File: rtl/reg_writeback_buffer.sv
// Writeback buffer in front of the register-file write port: a small FIFO of {reg, data}
// entries drained one per cycle, with two combinational read-bypass lookups.
module reg_writeback_buffer #(
   parameter int WORD  = 64,
   parameter int DEPTH = 4,
   parameter int ZR    = 31
) (
   input  logic                       read_clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [4:0]                 wb_reg,
   input  logic [WORD-1:0]            wb_data,
   input  logic                       drain_en,
   output logic                       reg_write,
   output logic [4:0]                 write_reg,
   output logic [WORD-1:0]            write_data,
   input  logic [4:0]                 byp_reg1,
   output logic                       byp_hit1,
   output logic [WORD-1:0]            byp_data1,
   input  logic [4:0]                 byp_reg2,
   output logic                       byp_hit2,
   output logic [WORD-1:0]            byp_data2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [4:0]    ZR_REG   = 5'(ZR);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic [4:0]      ent_reg_q  [DEPTH];
   logic [4:0]      ent_reg_d  [DEPTH];
   logic [WORD-1:0] ent_data_q [DEPTH];
   logic [WORD-1:0] ent_data_d [DEPTH];
   logic            reg_write_q, reg_write_d;
   logic [4:0]      write_reg_q, write_reg_d;
   logic [WORD-1:0] write_data_q, write_data_d;

   logic enq_s;
   logic store_s;
   logic drain_s;
   logic [WORD:0] byp1_s;
   logic [WORD:0] byp2_s;

   assign wb_ready   = (count_q != FULL_CNT);
   assign enq_s      = wb_valid && wb_ready && !flush;
   // Zero-register writes complete the handshake but never occupy an entry.
   assign store_s    = enq_s && (wb_reg != ZR_REG);
   assign drain_s    = drain_en && (count_q != {CW{1'b0}}) && !flush;

   assign count      = count_q;
   assign reg_write  = reg_write_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;

   // Next-state for pointers, entries, occupancy and the output stage.
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      ent_vld_d    = ent_vld_q;
      ent_reg_d    = ent_reg_q;
      ent_data_d   = ent_data_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (flush) begin
         head_d    = {PW{1'b0}};
         tail_d    = {PW{1'b0}};
         count_d   = {CW{1'b0}};
         ent_vld_d = {DEPTH{1'b0}};
      end else begin
         if (store_s) begin
            ent_reg_d[tail_q]  = wb_reg;
            ent_data_d[tail_q] = wb_data;
            ent_vld_d[tail_q]  = 1'b1;
            tail_d             = tail_q + PW'(1);
         end else begin
            tail_d = tail_q;
         end
         // Drain reads the pre-edge head, so a same-edge enqueue is never drained.
         if (drain_s) begin
            reg_write_d        = 1'b1;
            write_reg_d        = ent_reg_q[head_q];
            write_data_d       = ent_data_q[head_q];
            ent_vld_d[head_q]  = 1'b0;
            head_d             = head_q + PW'(1);
         end else begin
            reg_write_d = 1'b0;
         end
         case ({store_s, drain_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge read_clk) begin
      if (!reset) begin
         head_q       <= {PW{1'b0}};
         tail_q       <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         ent_vld_q    <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            ent_reg_q[i]  <= 5'd0;
            ent_data_q[i] <= {WORD{1'b0}};
         end
         reg_write_q  <= 1'b0;
         write_reg_q  <= 5'd0;
         write_data_q <= {WORD{1'b0}};
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         ent_vld_q    <= ent_vld_d;
         ent_reg_q    <= ent_reg_d;
         ent_data_q   <= ent_data_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Returns {hit, data}; output stage has lowest priority, newest FIFO entry highest.
   function automatic logic [WORD:0] byp_lookup(input logic [4:0] r);
      logic [WORD:0] res;
      logic [PW-1:0] idx;
      res = {(WORD+1){1'b0}};
      if (r != ZR_REG) begin
         if (reg_write_q && (write_reg_q == r)) begin
            res = {1'b1, write_data_q};
         end else begin
            res = {(WORD+1){1'b0}};
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (ent_vld_q[idx] && (ent_reg_q[idx] == r)) begin
               res = {1'b1, ent_data_q[idx]};
            end else begin
               res = res;
            end
         end
      end else begin
         res = {(WORD+1){1'b0}};
      end
      return res;
   endfunction

   // Combinational bypass lookups for both decode read ports.
   always_comb begin
      byp1_s = byp_lookup(byp_reg1);
      byp2_s = byp_lookup(byp_reg2);
   end

   assign byp_hit1  = byp1_s[WORD];
   assign byp_data1 = byp1_s[WORD-1:0];
   assign byp_hit2  = byp2_s[WORD];
   assign byp_data2 = byp2_s[WORD-1:0];

endmodule
